// File: rtl/sw_event_queue.sv
// rtl/sw_event_queue.sv - switch level-change detector with lowest-index-first event FIFO
module sw_event_queue #(
    parameter int NSW    = 18,
    parameter int IDX_W  = 5,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSW-1:0]    sw_clean,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDX_W-1:0]  evt_id,
    output logic              evt_level,
    output logic [ADDR_W:0]   evt_count,
    output logic [NSW-1:0]    sw_level,
    output logic              coalesced,
    input  logic              clr_flags
);

    localparam int              ENT_W     = IDX_W + 1;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [NSW-1:0]    sw_level_q,  sw_level_d;
    logic [NSW-1:0]    pending_q,   pending_d;
    logic              coalesced_q, coalesced_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;

    logic [NSW-1:0]    chg;
    logic [NSW-1:0]    grant_onehot;
    logic [IDX_W-1:0]  lowest_idx;
    logic              lowest_level;
    logic              any_pending;
    logic              pop;
    logic              push_ok;
    logic              push;
    logic              coalesce_hit;
    logic [ENT_W-1:0]  head;

    // Change detection and lowest-index arbitration over the pending mask
    always_comb begin
        chg          = sw_clean ^ sw_level_q;
        pop          = (count_q != '0) && evt_ready;
        push_ok      = (count_q < DEPTH_CNT) || pop;
        any_pending  = |pending_q;
        lowest_idx   = '0;
        lowest_level = 1'b0;
        // Scan downward so the last hit, the lowest set index, wins
        for (int i = NSW - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_idx   = IDX_W'(i);
                lowest_level = sw_level_q[i];
            end
        end
        push         = any_pending && push_ok;
        grant_onehot = push ? (NSW'(1) << lowest_idx) : '0;
    end

    // Pending mask, registered levels and the sticky coalesce flag
    always_comb begin
        sw_level_d   = sw_clean;
        // A fresh change on the bit being granted re-arms it for a later event
        pending_d    = (pending_q & ~grant_onehot) | chg;
        coalesce_hit = |(chg & pending_q & ~grant_onehot);
        coalesced_d  = coalesced_q;
        if (clr_flags) begin
            coalesced_d = 1'b0;
        end
        if (coalesce_hit) begin
            coalesced_d = 1'b1;
        end
    end

    // FIFO storage, pointers and occupancy; push and pop may share a cycle even when full
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {lowest_idx, lowest_level};
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards queued events and pending changes at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_level_q  <= '0;
            pending_q   <= '0;
            coalesced_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sw_level_q  <= sw_level_d;
            pending_q   <= pending_d;
            coalesced_q <= coalesced_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Fall-through head: outputs depend only on registered state, never on evt_ready
    always_comb begin
        head      = mem_q[rd_ptr_q];
        evt_valid = (count_q != '0);
        evt_id    = head[ENT_W-1:1];
        evt_level = head[0];
        evt_count = count_q;
        sw_level  = sw_level_q;
        coalesced = coalesced_q;
    end

endmodule
